// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer predictor.
package bp_pkg;

    localparam int CNT_W_DEF  = 2;
    localparam int ADDR_W_DEF = 32;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Weakly taken for any width: MSB set, remaining bits clear.
    function automatic logic [31:0] cnt_init(input int w);
        return 32'(1) << (w - 1);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] tag;
        logic [ADDR_W_DEF-1:0] target;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating direction counter; load (allocation) overrides inc/dec.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(cnt_init(CNT_W));
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/btb_predictor.sv
// Fully-associative BTB with registered lookup and round-robin allocation.
// Optional statistics counters are enabled with BTB_STATS_EN.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] f_predict_addr,
    output logic              f_predict_valid,
    output logic              f_hit,
    input  logic              x_update,
    input  logic [ADDR_W-1:0] x_pc,
    input  logic [ADDR_W-1:0] x_target,
    input  logic              x_taken
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_allocs
`endif
);

    localparam int PTR_W = $clog2(ENTRIES);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t                         tbl [ENTRIES];
    logic [PTR_W-1:0]               ptr;
    logic [ENTRIES-1:0]             f_match, x_match, cnt_msb, inc, dec, load;
    logic [ENTRIES-1:0][CNT_W-1:0]  cnt;
    logic                           upd, x_hit, alloc, f_any, f_taken;
    logic [ADDR_W-1:0]              f_tgt;

    assign upd   = x_update & ~reset;
    assign x_hit = |x_match;
    assign alloc = upd & ~x_hit & x_taken;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        assign f_match[i] = tbl[i].valid && (tbl[i].tag == f_pc);
        assign x_match[i] = tbl[i].valid && (tbl[i].tag == x_pc);
        assign cnt_msb[i] = cnt[i][CNT_W-1];
        assign inc[i]     = upd & x_match[i] & x_taken;
        assign dec[i]     = upd & x_match[i] & ~x_taken;
        assign load[i]    = alloc & (ptr == PTR_W'(i));

        bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[i]),
            .dec   (dec[i]),
            .load  (load[i]),
            .cnt   (cnt[i])
        );
    end

    // Allocation only on miss guarantees at most one match, so a plain OR merges hits.
    always_comb begin
        f_any   = |f_match;
        f_tgt   = '0;
        f_taken = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            if (f_match[k]) begin
                f_tgt   = f_tgt | tbl[k].target;
                f_taken = f_taken | cnt_msb[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++)
                tbl[k].valid <= 1'b0;
            ptr             <= '0;
            f_hit           <= 1'b0;
            f_predict_valid <= 1'b0;
            f_predict_addr  <= '0;
        end else begin
            f_hit           <= f_any;
            f_predict_valid <= f_any & f_taken;
            f_predict_addr  <= f_tgt;
            for (int k = 0; k < ENTRIES; k++) begin
                if (inc[k])
                    tbl[k].target <= x_target;
                if (load[k])
                    tbl[k] <= '{valid: 1'b1, tag: x_pc, target: x_target};
            end
            if (alloc)
                ptr <= (ptr == PTR_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_allocs  <= '0;
        end else begin
            stat_lookups <= stat_lookups + 1'b1;
            if (f_any)
                stat_hits <= stat_hits + 1'b1;
            if (alloc)
                stat_allocs <= stat_allocs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed checks of lookup, counter training, allocation and reset priority.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc, f_predict_addr, x_pc, x_target;
    logic        f_predict_valid, f_hit, x_update, x_taken;
    int          total = 0;
    int          bad   = 0;

    btb_predictor #(.ENTRIES(4), .ADDR_W(32), .CNT_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .f_pc            (f_pc),
        .f_predict_addr  (f_predict_addr),
        .f_predict_valid (f_predict_valid),
        .f_hit           (f_hit),
        .x_update        (x_update),
        .x_pc            (x_pc),
        .x_target        (x_target),
        .x_taken         (x_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic hit, input logic pv, input logic [31:0] addr);
        total++;
        assert (f_hit === hit && f_predict_valid === pv && f_predict_addr === addr) else begin
            bad++;
            $error("FAIL %s got hit=%b pv=%b addr=%h exp hit=%b pv=%b addr=%h",
                   tag, f_hit, f_predict_valid, f_predict_addr, hit, pv, addr);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        x_update = 1'b1; x_pc = pc; x_target = tgt; x_taken = tk;
        @(posedge clk); @(negedge clk);
        x_update = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic pv, input logic [31:0] addr);
        f_pc = pc;
        @(posedge clk); @(negedge clk);
        chk(tag, hit, pv, addr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; f_pc = 32'h100; x_update = 1'b0; x_pc = '0; x_target = '0; x_taken = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", 1'b0, 1'b0, 32'h0);
        reset = 1'b0;

        // 1: empty table misses
        look("t1_miss", 32'h100, 1'b0, 1'b0, 32'h0);

        // 2: allocate, weakly taken
        upd(32'h100, 32'h200, 1'b1);
        look("t2_alloc_hit", 32'h100, 1'b1, 1'b1, 32'h200);

        // 3: training; untaken keeps target, saturate at both ends
        upd(32'h100, 32'h999, 1'b0);
        look("t3_wnt", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 32'h999, 1'b0);
        look("t3_snt", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 32'h999, 1'b0);
        upd(32'h100, 32'h250, 1'b1);
        look("t3_snt_sat_then_wnt", 32'h100, 1'b1, 1'b0, 32'h250);
        upd(32'h100, 32'h260, 1'b1);
        look("t3_wt_again", 32'h100, 1'b1, 1'b1, 32'h260);
        upd(32'h100, 32'h260, 1'b1);
        upd(32'h100, 32'h260, 1'b1);
        upd(32'h100, 32'h260, 1'b0);
        look("t3_st_sat_then_wt", 32'h100, 1'b1, 1'b1, 32'h260);
        upd(32'h100, 32'h260, 1'b0);
        look("t3_wnt_after_sat", 32'h100, 1'b1, 1'b0, 32'h260);

        // 4: round-robin replacement
        do_reset();
        upd(32'h10, 32'h1010, 1'b1);
        upd(32'h20, 32'h1020, 1'b1);
        upd(32'h30, 32'h1030, 1'b1);
        upd(32'h40, 32'h1040, 1'b1);
        upd(32'h50, 32'h1050, 1'b1);
        look("t4_evicted_10", 32'h10, 1'b0, 1'b0, 32'h0);
        look("t4_hit_20", 32'h20, 1'b1, 1'b1, 32'h1020);
        look("t4_hit_30", 32'h30, 1'b1, 1'b1, 32'h1030);
        look("t4_hit_40", 32'h40, 1'b1, 1'b1, 32'h1040);
        look("t4_hit_50", 32'h50, 1'b1, 1'b1, 32'h1050);

        // 5: untaken miss allocates nothing; next allocation still lands on entry 1 (0x20)
        upd(32'h300, 32'h3300, 1'b0);
        look("t5_no_alloc", 32'h300, 1'b0, 1'b0, 32'h0);
        upd(32'h60, 32'h1060, 1'b1);
        look("t5_ptr_evicts_20", 32'h20, 1'b0, 1'b0, 32'h0);
        look("t5_hit_30", 32'h30, 1'b1, 1'b1, 32'h1030);
        look("t5_hit_60", 32'h60, 1'b1, 1'b1, 32'h1060);

        // 6: no forwarding of same-cycle update
        f_pc = 32'h400;
        x_update = 1'b1; x_pc = 32'h400; x_target = 32'h4a0; x_taken = 1'b1;
        @(posedge clk); @(negedge clk);
        x_update = 1'b0;
        chk("t6_no_forward", 1'b0, 1'b0, 32'h0);
        look("t6_hit_next", 32'h400, 1'b1, 1'b1, 32'h4a0);

        // reset beats a concurrent update
        reset = 1'b1;
        x_update = 1'b1; x_pc = 32'h500; x_target = 32'h5a0; x_taken = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; x_update = 1'b0;
        chk("t6_reset_outputs", 1'b0, 1'b0, 32'h0);
        look("t6_update_discarded", 32'h500, 1'b0, 1'b0, 32'h0);
        look("t6_entries_cleared", 32'h400, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
